// File: rtl/avl_sample_window_pkg.sv
// Shared register map, bit positions and defaults for the sample-window slave.
package avl_sample_window_pkg;
  localparam logic [13:0] ADDR_ID     = 14'd0;
  localparam logic [13:0] ADDR_CTRL   = 14'd1;
  localparam logic [13:0] ADDR_STATUS = 14'd2;
  localparam logic [13:0] ADDR_ACK    = 14'd3;
  localparam logic [13:0] ADDR_BASE   = 14'd4;
  localparam logic [13:0] ADDR_CNT    = 14'd5;
  localparam logic [13:0] BUF_BASE    = 14'h1000;

  localparam int ST_ACTIVE = 0;
  localparam int ST_READY  = 1;
  localparam int ST_OVF    = 2;
  localparam int ACK_READY = 1;
  localparam int ACK_OVF   = 2;

  localparam logic [15:0] ID_VAL_DEF = 16'h5A17;
endpackage

// File: rtl/sample_ram_sp.sv
// Single-port 16-bit RAM; read data only updates on read cycles so it holds across sample writes.
module sample_ram_sp #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o
);
  logic [15:0] mem_q [DEPTH];
  logic [15:0] rdata_q;

  always_ff @(posedge clk_i)
    if (en_i && we_i) mem_q[addr_i] <= wdata_i;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni)              rdata_q <= '0;
    else if (en_i && !we_i)   rdata_q <= mem_q[addr_i];

  assign rdata_o = rdata_q;
endmodule

// File: rtl/avl_sample_window_slave.sv
// Avalon-MM slave capturing a sample stream into a ring buffer and flagging completed windows.
module avl_sample_window_slave
  import avl_sample_window_pkg::*;
#(
  parameter int          DEPTH  = 1024,
  parameter int          WINDOW = 150,
  parameter logic [15:0] ID_VAL = ID_VAL_DEF
) (
  input  logic        avl_clk_i,
  input  logic        avl_reset_i,
  input  logic [13:0] avl_address_i,
  input  logic [3:0]  avl_byteenable_i,
  input  logic        avl_write_i,
  input  logic [15:0] avl_writedata_i,
  input  logic        avl_read_i,
  output logic        avl_readdatavalid_o,
  output logic [15:0] avl_readdata_o,
  output logic        avl_waitrequest_o,
  output logic        avl_irq_o,
  input  logic [15:0] sample_i,
  input  logic        sample_valid_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WINDOW + 1);
  localparam logic [31:0] BUF_LIM = 32'(BUF_BASE) + 32'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, base_q, base_d;
  logic [CW-1:0] win_cnt_q, win_cnt_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          active_q, active_d, ready_q, ready_d, ovf_q, ovf_d;
  logic          irq_q, rvld_q, src_buf_q;
  logic [15:0]   reg_rd_q, reg_rdata, ram_dout;

  logic [13:0]   buf_off;
  logic          in_buf, samp_acc, wr_acc, rd_acc, lo_we, ctrl_wr, ack_rdy, ack_ovf, win_done;

  assign buf_off  = avl_address_i - BUF_BASE;
  assign in_buf   = (avl_address_i >= BUF_BASE) && ({18'd0, avl_address_i} < BUF_LIM);
  assign samp_acc = active_q & sample_valid_i;

  // The sample write owns the RAM port this cycle, so a buffer read must wait.
  assign avl_waitrequest_o = avl_read_i & in_buf & sample_valid_i & active_q;

  assign wr_acc   = avl_write_i & ~avl_waitrequest_o;
  assign rd_acc   = avl_read_i & ~avl_write_i & ~avl_waitrequest_o;
  assign lo_we    = wr_acc & avl_byteenable_i[0];
  assign ctrl_wr  = lo_we && (avl_address_i == ADDR_CTRL);
  assign ack_rdy  = lo_we && (avl_address_i == ADDR_ACK) && avl_writedata_i[ACK_READY];
  assign ack_ovf  = lo_we && (avl_address_i == ADDR_ACK) && avl_writedata_i[ACK_OVF];
  assign win_done = samp_acc && (win_cnt_q == CW'(WINDOW - 1));

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    base_d    = base_q;
    win_cnt_d = win_cnt_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    ready_d   = ready_q;
    ovf_d     = ovf_q;
    if (samp_acc) begin
      wr_ptr_d  = wr_ptr_q + 1'b1;
      cnt_d     = cnt_q + 16'd1;
      win_cnt_d = win_done ? '0 : win_cnt_q + 1'b1;
    end
    if (ack_rdy) ready_d = 1'b0;
    if (ack_ovf) ovf_d   = 1'b0;
    // A coincident ACK frees the slot, so the new window lands instead of overflowing.
    if (win_done) begin
      if (ready_q && !ack_rdy) ovf_d = 1'b1;
      else begin
        ready_d = 1'b1;
        base_d  = wr_ptr_q - AW'(WINDOW - 1);
      end
    end
    if (ctrl_wr) begin
      if (avl_writedata_i[0]) begin
        if (!active_q) begin
          active_d  = 1'b1;
          wr_ptr_d  = '0;
          win_cnt_d = '0;
          cnt_d     = '0;
          ready_d   = 1'b0;
          ovf_d     = 1'b0;
        end
      end else begin
        active_d  = 1'b0;
        win_cnt_d = '0;
      end
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (avl_address_i)
      ADDR_ID:     reg_rdata = ID_VAL;
      ADDR_CTRL:   reg_rdata[0] = active_q;
      ADDR_STATUS: begin
        reg_rdata[ST_ACTIVE] = active_q;
        reg_rdata[ST_READY]  = ready_q;
        reg_rdata[ST_OVF]    = ovf_q;
      end
      ADDR_BASE:   reg_rdata = 16'(base_q);
      ADDR_CNT:    reg_rdata = cnt_q;
      default:     reg_rdata = '0;
    endcase
  end

  always_ff @(posedge avl_clk_i or negedge avl_reset_i)
    if (!avl_reset_i) begin
      wr_ptr_q  <= '0;
      base_q    <= '0;
      win_cnt_q <= '0;
      cnt_q     <= '0;
      active_q  <= 1'b0;
      ready_q   <= 1'b0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
      rvld_q    <= 1'b0;
      src_buf_q <= 1'b0;
      reg_rd_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      base_q    <= base_d;
      win_cnt_q <= win_cnt_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      ready_q   <= ready_d;
      ovf_q     <= ovf_d;
      irq_q     <= ready_q;
      rvld_q    <= rd_acc;
      if (rd_acc) begin
        src_buf_q <= in_buf;
        if (!in_buf) reg_rd_q <= reg_rdata;
      end
    end

  sample_ram_sp #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_i   (avl_clk_i),
    .rst_ni  (avl_reset_i),
    .en_i    (samp_acc | (rd_acc & in_buf)),
    .we_i    (samp_acc),
    .addr_i  (samp_acc ? wr_ptr_q : buf_off[AW-1:0]),
    .wdata_i (sample_i),
    .rdata_o (ram_dout)
  );

  assign avl_readdata_o      = src_buf_q ? ram_dout : reg_rd_q;
  assign avl_readdatavalid_o = rvld_q;
  assign avl_irq_o           = irq_q;

  logic unused_bits;
  assign unused_bits = ^{avl_byteenable_i[3:1], avl_writedata_i[15:3], buf_off[13:AW]};
endmodule
